// File: rtl/fuzzy_risk_scheduler.sv
// Round-robin scheduler that shares one fuzzy risk engine among N_CH sensor channels,
// with an engine timeout and a per-channel alarm with hysteresis.
module fuzzy_risk_scheduler #(
    parameter  int unsigned N_CH    = 4,
    parameter  int unsigned TIMEOUT = 64,
    localparam int unsigned CHW     = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   ch_req,
    input  logic [8*N_CH-1:0] ch_rain,
    input  logic [8*N_CH-1:0] ch_soil,
    output logic [N_CH-1:0]   ch_ack,
    input  logic [7:0]        thr_hi,
    input  logic [7:0]        thr_lo,
    output logic              eng_start,
    output logic [7:0]        eng_rain,
    output logic [7:0]        eng_soil,
    input  logic              eng_done,
    input  logic [7:0]        eng_risk,
    output logic              res_valid,
    output logic [CHW-1:0]    res_ch,
    output logic [7:0]        res_risk,
    output logic              res_err,
    output logic [N_CH-1:0]   alarm,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REPORT} state_t;

    state_t          state_q, state_d;
    logic [CHW-1:0]  rr_q, grant_q, gnt;
    logic            found;
    logic [15:0]     timer_q;
    logic [7:0]      risk_q;
    logic            err_q;
    logic [7:0]      rain_sel, soil_sel, rain_clamp, soil_clamp;
    logic            expire;
    int unsigned     idx;

    // First requesting channel at or after the rr pointer, wrapping.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            idx = (32'(rr_q) + i) % N_CH;
            if (!found && ch_req[idx[CHW-1:0]]) begin
                found = 1'b1;
                gnt   = idx[CHW-1:0];
            end
        end
    end

    assign rain_sel   = ch_rain[{gnt, 3'b000} +: 8];
    assign soil_sel   = ch_soil[{gnt, 3'b000} +: 8];
    assign rain_clamp = (rain_sel > 8'd100) ? 8'd100 : rain_sel;
    assign soil_clamp = (soil_sel > 8'd100) ? 8'd100 : soil_sel;

    // Abort when the incremented timer would reach TIMEOUT-1; last WAIT cycle still accepts done.
    assign expire = ({16'd0, timer_q} + 32'd1) >= (TIMEOUT - 32'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ch_ack  = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = ISSUE;
                    if (rst_n) ch_ack[gnt] = 1'b1;
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT:    if (eng_done || expire) state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q     <= '0;
            grant_q  <= '0;
            timer_q  <= '0;
            risk_q   <= '0;
            err_q    <= 1'b0;
            eng_rain <= '0;
            eng_soil <= '0;
            alarm    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_q  <= gnt;
                        eng_rain <= rain_clamp;
                        eng_soil <= soil_clamp;
                    end
                end
                ISSUE: timer_q <= '0;
                WAIT: begin
                    if (eng_done) begin
                        risk_q <= eng_risk;
                        err_q  <= 1'b0;
                    end else if (expire) begin
                        risk_q <= '0;
                        err_q  <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                REPORT: begin
                    rr_q <= (grant_q == CHW'(N_CH - 1)) ? '0 : grant_q + 1'b1;
                    if (!err_q) begin
                        if (risk_q >= thr_hi)     alarm[grant_q] <= 1'b1;
                        else if (risk_q < thr_lo) alarm[grant_q] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign eng_start = (state_q == ISSUE);
    assign res_valid = (state_q == REPORT);
    assign res_ch    = res_valid ? grant_q : '0;
    assign res_risk  = res_valid ? risk_q  : '0;
    assign res_err   = res_valid ? err_q   : 1'b0;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fuzzy_risk_scheduler.sv
// Self-checking bench for fuzzy_risk_scheduler: directed scenarios plus randomized
// transactions checked against a behavioural arbitration/alarm model.
module tb_fuzzy_risk_scheduler;

    localparam int N_CH    = 4;
    localparam int TIMEOUT = 64;
    localparam int CHW     = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_CH-1:0]   ch_req;
    logic [8*N_CH-1:0] ch_rain, ch_soil;
    logic [N_CH-1:0]   ch_ack;
    logic [7:0]        thr_hi, thr_lo;
    logic              eng_start;
    logic [7:0]        eng_rain, eng_soil;
    logic              eng_done;
    logic [7:0]        eng_risk;
    logic              res_valid;
    logic [CHW-1:0]    res_ch;
    logic [7:0]        res_risk;
    logic              res_err;
    logic [N_CH-1:0]   alarm;
    logic              busy;

    fuzzy_risk_scheduler #(.N_CH(N_CH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_rain(ch_rain), .ch_soil(ch_soil),
        .ch_ack(ch_ack), .thr_hi(thr_hi), .thr_lo(thr_lo), .eng_start(eng_start),
        .eng_rain(eng_rain), .eng_soil(eng_soil), .eng_done(eng_done), .eng_risk(eng_risk),
        .res_valid(res_valid), .res_ch(res_ch), .res_risk(res_risk), .res_err(res_err),
        .alarm(alarm), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: rr pointer and alarm bits only.
    int          rr_m;
    bit [N_CH-1:0] alarm_m;

    typedef struct {
        logic [N_CH-1:0] ack, ack_after, alm;
        logic            st, start_extra, stable, err;
        logic [7:0]      er, es, risk;
        logic [CHW-1:0]  rch;
        int              cyc;
    } obs_t;

    function automatic int pick(input logic [N_CH-1:0] req);
        for (int k = 0; k < N_CH; k++) begin
            int c;
            c = (rr_m + k) % N_CH;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    function automatic void model_report(input int g, input int risk, input bit err);
        if (!err) begin
            if (risk >= int'(thr_hi))     alarm_m[g] = 1'b1;
            else if (risk < int'(thr_lo)) alarm_m[g] = 1'b0;
        end
        rr_m = (g + 1) % N_CH;
    endfunction

    function automatic int clampv(input int v);
        return (v > 100) ? 100 : v;
    endfunction

    task automatic set_ch(input int c, input int rain, input int soil);
        ch_rain[8*c +: 8] = 8'(rain);
        ch_soil[8*c +: 8] = 8'(soil);
    endtask

    // Engine responder: lat=0 never answers; otherwise done in the lat-th WAIT cycle.
    task automatic serve(input int lat, input logic [7:0] risk, input bit drop, output obs_t o);
        int t;
        o = '{ack: '0, ack_after: '0, alm: '0, st: 0, start_extra: 0, stable: 0, err: 0,
              er: '0, es: '0, risk: '0, rch: '0, cyc: -1};
        t = 0;
        #1;
        while (ch_ack == '0 && t < 50) begin @(negedge clk); #1; t++; end
        o.ack = ch_ack;
        if (o.ack == '0) return;
        @(negedge clk); #1;
        o.ack_after = ch_ack;
        o.st = eng_start; o.er = eng_rain; o.es = eng_soil;
        o.stable = 1'b1;
        if (drop) ch_req = ch_req & ~o.ack;
        for (int n = 1; n <= TIMEOUT + 20; n++) begin
            @(negedge clk); #1;
            if (res_valid) begin
                o.cyc = n; o.rch = res_ch; o.risk = res_risk; o.err = res_err;
                break;
            end
            if (eng_start) o.start_extra = 1'b1;
            if (eng_rain !== o.er || eng_soil !== o.es) o.stable = 1'b0;
            eng_done = (n == lat);
            eng_risk = risk;
        end
        eng_done = 1'b0;
        @(negedge clk); #1;
        o.alm = alarm;
    endtask

    task automatic test_reset;
        ch_req = 4'hF;
        for (int c = 0; c < N_CH; c++) set_ch(c, 200, 200);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({ch_ack, eng_start, eng_rain, eng_soil, res_valid, res_ch, res_risk, res_err, alarm, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: ack=%b start=%b rain=%0d soil=%0d rv=%b rch=%0d risk=%0d err=%b alarm=%b busy=%b, all required 0",
                     ch_ack, eng_start, eng_rain, eng_soil, res_valid, res_ch, res_risk, res_err, alarm, busy);
        end
        ch_req = '0;
        rst_n = 1'b1;
        rr_m = 0; alarm_m = '0;
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        obs_t o;
        int g;
        thr_hi = 8'd200; thr_lo = 8'd100;
        for (int c = 0; c < N_CH; c++) set_ch(c, 10 * c, 20 * c);
        ch_req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            g = pick(ch_req);
            serve(3, 8'd120, 1'b0, o);
            model_report(g, 120, 1'b0);
            vectors++;
            if (o.ack !== (4'b0001 << (k % N_CH)) || o.ack !== (4'b0001 << g)) begin
                miscompares++;
                $display("FAIL rr_grant[%0d]: ack=%b required=%b", k, o.ack, 4'b0001 << (k % N_CH));
            end
            vectors++;
            if (o.cyc !== 4 || o.rch !== CHW'(g)) begin
                miscompares++;
                $display("FAIL rr_result[%0d]: cyc=%0d ch=%0d required cyc=4 ch=%0d", k, o.cyc, o.rch, g);
            end
        end
        ch_req = '0;
    endtask

    task automatic test_basic;
        obs_t o;
        thr_hi = 8'd200; thr_lo = 8'd100;
        set_ch(2, 80, 80);
        ch_req = 4'b0100;
        serve(5, 8'd255, 1'b1, o);
        model_report(2, 255, 1'b0);
        vectors++;
        if (o.ack !== 4'b0100 || o.ack_after !== 4'b0000) begin
            miscompares++;
            $display("FAIL basic_ack: ack=%b next=%b required 0100 then 0000", o.ack, o.ack_after);
        end
        vectors++;
        if (o.st !== 1'b1 || o.start_extra !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_start: start=%b extra=%b required 1,0", o.st, o.start_extra);
        end
        vectors++;
        if (o.cyc !== 6 || o.rch !== 2'd2 || o.risk !== 8'd255 || o.err !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_result: cyc=%0d ch=%0d risk=%0d err=%b required 6,2,255,0", o.cyc, o.rch, o.risk, o.err);
        end
        vectors++;
        if (o.alm !== alarm_m || o.alm[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_alarm: alarm=%b required %b", o.alm, alarm_m);
        end
    endtask

    task automatic test_clamp;
        obs_t o;
        int g;
        set_ch(1, 150, 255);
        ch_req = 4'b0010;
        g = pick(ch_req);
        serve(8, 8'd40, 1'b1, o);
        model_report(g, 40, 1'b0);
        vectors++;
        if (o.er !== 8'd100 || o.es !== 8'd100 || o.stable !== 1'b1) begin
            miscompares++;
            $display("FAIL clamp: rain=%0d soil=%0d stable=%b required 100,100,1", o.er, o.es, o.stable);
        end
        set_ch(1, 100, 101);
        ch_req = 4'b0010;
        g = pick(ch_req);
        serve(2, 8'd40, 1'b1, o);
        model_report(g, 40, 1'b0);
        vectors++;
        if (o.er !== 8'd100 || o.es !== 8'd100) begin
            miscompares++;
            $display("FAIL clamp_edge: rain=%0d soil=%0d required 100,100", o.er, o.es);
        end
    endtask

    task automatic test_timeout;
        obs_t o;
        thr_hi = 8'd200; thr_lo = 8'd100;
        set_ch(3, 50, 50);
        ch_req = 4'b1000;
        serve(4, 8'd250, 1'b1, o);
        model_report(3, 250, 1'b0);
        thr_hi = 8'd255; thr_lo = 8'd255;
        ch_req = 4'b1000;
        serve(0, 8'd0, 1'b1, o);
        model_report(3, 0, 1'b1);
        vectors++;
        if (o.cyc !== TIMEOUT || o.err !== 1'b1 || o.risk !== 8'd0) begin
            miscompares++;
            $display("FAIL timeout_result: cyc=%0d err=%b risk=%0d required %0d,1,0", o.cyc, o.err, o.risk, TIMEOUT);
        end
        vectors++;
        if (o.alm !== alarm_m || o.alm[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_alarm: alarm=%b required %b", o.alm, alarm_m);
        end
        eng_done = 1'b1; eng_risk = 8'd99;
        @(negedge clk);
        eng_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            vectors++;
            if (res_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL late_done[%0d]: res_valid=%b busy=%b required 0,0", k, res_valid, busy);
            end
            @(negedge clk);
        end
        thr_hi = 8'd200; thr_lo = 8'd100;
        ch_req = 4'b1000;
        serve(TIMEOUT - 1, 8'd50, 1'b1, o);
        model_report(3, 50, 1'b0);
        vectors++;
        if (o.cyc !== TIMEOUT || o.err !== 1'b0 || o.risk !== 8'd50 || o.alm !== alarm_m) begin
            miscompares++;
            $display("FAIL done_at_expiry: cyc=%0d err=%b risk=%0d alarm=%b required %0d,0,50,%b",
                     o.cyc, o.err, o.risk, o.alm, TIMEOUT, alarm_m);
        end
    endtask

    task automatic test_hysteresis;
        obs_t o;
        int risks [5] = '{210, 150, 90, 150, 210};
        bit exp_a [5] = '{1, 1, 0, 0, 1};
        set_ch(0, 30, 30);
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin thr_hi = 8'd200; thr_lo = 8'd220; end
            else        begin thr_hi = 8'd200; thr_lo = 8'd100; end
            ch_req = 4'b0001;
            serve(2, 8'(risks[k]), 1'b1, o);
            model_report(0, risks[k], 1'b0);
            vectors++;
            if (o.alm[0] !== exp_a[k] || o.alm !== alarm_m) begin
                miscompares++;
                $display("FAIL hysteresis[%0d]: alarm=%b required %b (bit0=%0d)", k, o.alm, alarm_m, exp_a[k]);
            end
        end
    endtask

    task automatic test_reset_in_wait;
        obs_t o;
        int t;
        thr_hi = 8'd200; thr_lo = 8'd100;
        set_ch(1, 60, 60); set_ch(3, 70, 70);
        ch_req = 4'b0010;
        serve(2, 8'd10, 1'b1, o);
        model_report(1, 10, 1'b0);
        ch_req = 4'b0010;
        t = 0; #1;
        while (ch_ack == '0 && t < 20) begin @(negedge clk); #1; t++; end
        vectors++;
        if (ch_ack !== 4'b0010) begin
            miscompares++;
            $display("FAIL rstwait_grant: ack=%b required 0010", ch_ack);
        end
        @(negedge clk); #1;
        ch_req = '0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rstwait_busy_before: busy=%b required 1", busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rr_m = 0; alarm_m = '0;
        #1;
        vectors++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || alarm !== '0) begin
            miscompares++;
            $display("FAIL rstwait_idle: busy=%b res_valid=%b alarm=%b required 0,0,0", busy, res_valid, alarm);
        end
        eng_done = 1'b1; eng_risk = 8'd250;
        @(negedge clk);
        eng_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            vectors++;
            if (res_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rstwait_ignored[%0d]: res_valid=%b busy=%b required 0,0", k, res_valid, busy);
            end
            @(negedge clk);
        end
        ch_req = 4'b1010;
        serve(3, 8'd220, 1'b1, o);
        model_report(1, 220, 1'b0);
        vectors++;
        if (o.ack !== 4'b0010 || o.rch !== 2'd1 || o.alm !== alarm_m) begin
            miscompares++;
            $display("FAIL rstwait_next: ack=%b ch=%0d alarm=%b required 0010,1,%b", o.ack, o.rch, o.alm, alarm_m);
        end
        ch_req = '0;
        @(negedge clk);
    endtask

    task automatic test_random;
        obs_t o;
        int g, lat, rk;
        int rain [N_CH];
        int soil [N_CH];
        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < N_CH; c++) begin
                rain[c] = $urandom_range(0, 255);
                soil[c] = $urandom_range(0, 255);
                set_ch(c, rain[c], soil[c]);
            end
            thr_hi = 8'($urandom_range(0, 255));
            thr_lo = 8'($urandom_range(0, 255));
            lat = $urandom_range(1, 12);
            rk  = $urandom_range(0, 255);
            ch_req = 4'($urandom_range(1, 15));
            g = pick(ch_req);
            serve(lat, 8'(rk), 1'b1, o);
            model_report(g, rk, 1'b0);
            vectors++;
            if (o.ack !== (4'b0001 << g) || o.rch !== CHW'(g)) begin
                miscompares++;
                $display("FAIL rand_grant[%0d]: ack=%b ch=%0d required ch %0d", it, o.ack, o.rch, g);
            end
            vectors++;
            if (o.er !== 8'(clampv(rain[g])) || o.es !== 8'(clampv(soil[g])) || o.stable !== 1'b1) begin
                miscompares++;
                $display("FAIL rand_operands[%0d]: rain=%0d soil=%0d stable=%b required %0d,%0d,1",
                         it, o.er, o.es, o.stable, clampv(rain[g]), clampv(soil[g]));
            end
            vectors++;
            if (o.cyc !== lat + 1 || o.risk !== 8'(rk) || o.err !== 1'b0 || o.alm !== alarm_m) begin
                miscompares++;
                $display("FAIL rand_result[%0d]: cyc=%0d risk=%0d err=%b alarm=%b required %0d,%0d,0,%b",
                         it, o.cyc, o.risk, o.err, o.alm, lat + 1, rk, alarm_m);
            end
        end
        ch_req = '0;
    endtask

    initial begin
        rst_n = 1'b0; ch_req = '0; ch_rain = '0; ch_soil = '0;
        thr_hi = 8'd200; thr_lo = 8'd100; eng_done = 1'b0; eng_risk = '0;
        rr_m = 0; alarm_m = '0;
        @(negedge clk);
        test_reset;
        test_round_robin;
        test_basic;
        test_clamp;
        test_timeout;
        test_hysteresis;
        test_reset_in_wait;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
